// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Build with DMEM_RANGE_CHECK_EN defined to enable address range/alignment errors.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Byte address to word index; the caller truncates to its own index width.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// Synchronous DEPTH x DATA_W storage: one write and one registered read per edge, no reset.
// A read of the word being written on the same edge returns the new data.
module dmem_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store data-memory target with a fixed, programmable response latency.
// Optional DMEM_RANGE_CHECK_EN adds resp_err for misaligned or out-of-range addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic              resp_err
`endif
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_n;
    logic              accept;
    logic [ADDR_W-1:0] req_idx;
    logic              req_err;
    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic              rdata_sel;
    logic [ADDR_W-1:0] svc_idx;
    logic              svc_we;
    logic              svc_err;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] ram_q;

    assign accept  = req_valid & req_ready;
    assign req_idx = ADDR_W'(word_index(req_addr));

`ifdef DMEM_RANGE_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != 32'd0);
`else
    assign req_err = 1'b0;
`endif

    // With LATENCY=1 the read happens on the accepting edge, before the latch holds the request.
    assign svc_idx = (LATENCY == 1) ? req_idx : idx_q;
    assign svc_we  = (LATENCY == 1) ? req_we  : we_q;
    assign svc_err = (LATENCY == 1) ? req_err : err_q;

    assign rd_en = (state_n == ST_RESP) & ~svc_we & ~svc_err;
    assign wr_en = (state == ST_RESP) & we_q & ~err_q;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt == CNT_W'(1)) state_n = ST_RESP;
            ST_RESP: begin
                if (accept) state_n = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                else        state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata_sel  <= 1'b0;
            cnt        <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            req_ready  <= (state_n != ST_WAIT);
            resp_valid <= (state_n == ST_RESP);
            rdata_sel  <= rd_en;
            if (accept) begin
                idx_q   <= req_idx;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                cnt     <= CNT_LOAD;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_err <= 1'b0;
        end else begin
            resp_err <= (state_n == ST_RESP) & svc_err;
        end
    end
`endif

    assign resp_rdata = rdata_sel ? ram_q : '0;

    dmem_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_idx  (svc_idx),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance behind one shared request driver.
// Define DMEM_RANGE_CHECK_EN to also exercise resp_err.
module tb_dmem_responder;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              sel;
    logic              req_valid;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              valid2, ready2, rvalid2;
    logic              valid1, ready1, rvalid1;
    logic [DATA_W-1:0] rdata2, rdata1;
    logic              ready_o, rvalid_o, err_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err2, err1;

    assign valid2 = req_valid & ~sel;
    assign valid1 = req_valid & sel;

    dmem_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(2)) u_l2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (valid2),
        .req_ready  (ready2),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .resp_valid (rvalid2),
        .resp_rdata (rdata2)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .resp_err   (err2)
`endif
    );

    dmem_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1)) u_l1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (valid1),
        .req_ready  (ready1),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .resp_valid (rvalid1),
        .resp_rdata (rdata1)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .resp_err   (err1)
`endif
    );

`ifndef DMEM_RANGE_CHECK_EN
    assign err2 = 1'b0;
    assign err1 = 1'b0;
`endif

    assign ready_o  = sel ? ready1  : ready2;
    assign rvalid_o = sel ? rvalid1 : rvalid2;
    assign rdata_o  = sel ? rdata1  : rdata2;
    assign err_o    = sel ? err1    : err2;

    // Reference memory contents, one image per instance.
    logic [DATA_W-1:0] model [2][DEPTH];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_index(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    function automatic bit exp_err(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
        return (a % 4 != 0) || (a >= DEPTH * 4);
`else
        return (a == 32'hffff_ffff) && (a != 32'hffff_ffff);
`endif
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << (ADDR_W + 2));
        return a;
    endfunction

    // One isolated op: wait for ready, hold valid through the accepting edge, then time the response.
    task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int wt;
        int exp_lat;
        bit e;
        int unsigned idx;
        exp_lat = sel ? 1 : 2;
        e = exp_err(addr);
        idx = exp_index(addr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        wt = 0;
        while (ready_o !== 1'b1 && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        check("accept_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (rvalid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_latency", n, exp_lat);
        check("resp_rdata", rdata_o, (we || e) ? 32'd0 : model[sel][idx]);
`ifdef DMEM_RANGE_CHECK_EN
        check("resp_err", 32'(err_o), 32'(e));
`endif
        @(negedge clk);
        check("resp_pulse", 32'(rvalid_o), 32'd0);
        if (we && !e) model[sel][idx] = wdata;
    endtask

    initial begin
        logic [31:0] old_val;
        logic [31:0] d;
        logic [31:0] a [5];
        logic [31:0] e [5];

        sel = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;

        // Reset values on both instances.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_ready", 32'(ready_o), 32'd1);
            check("rst_valid", 32'(rvalid_o), 32'd0);
            check("rst_rdata", rdata_o, 32'd0);
            check("rst_err", 32'(err_o), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Fill the words the rest of the bench touches.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 16; w++) do_op(1'b1, 32'(w * 4), $urandom);
        end

        // Store then load at LATENCY=2.
        sel = 1'b0;
        do_op(1'b1, 32'h10, 32'hdeadbeef);
        do_op(1'b0, 32'h10, 32'h0);

        // Back-to-back: load accepted in the store's response cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11;
        check("b2b_ready0", 32'(ready_o), 32'd1);
        @(posedge clk); @(negedge clk);
        req_we = 1'b0;
        check("b2b_wait_ready", 32'(ready_o), 32'd0);
        check("b2b_wait_valid", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        check("b2b_st_valid", 32'(rvalid_o), 32'd1);
        check("b2b_st_rdata", rdata_o, 32'd0);
        check("b2b_st_ready", 32'(ready_o), 32'd1);
        model[0][8] = 32'h11;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_ld_wait_ready", 32'(ready_o), 32'd0);
        check("b2b_ld_wait_valid", 32'(rvalid_o), 32'd0);
        @(negedge clk);
        check("b2b_ld_valid", 32'(rvalid_o), 32'd1);
        check("b2b_ld_rdata", rdata_o, 32'h11);
        @(negedge clk);
        check("b2b_idle_valid", 32'(rvalid_o), 32'd0);
        check("b2b_idle_ready", 32'(ready_o), 32'd1);

        // LATENCY=1 stream: a store, then four loads with valid held high (first load reads the store).
        sel = 1'b1;
        d = $urandom;
        a[0] = 32'($urandom_range(0, 15)) * 4;
        for (int i = 1; i < 5; i++) a[i] = (i == 1) ? a[0] : 32'($urandom_range(0, 15)) * 4;
        model[1][exp_index(a[0])] = d;
        e[0] = 32'd0;
        for (int i = 1; i < 5; i++) e[i] = model[1][exp_index(a[i])];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a[0]; req_wdata = d;
        check("l1_ready0", 32'(ready_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("l1_stream_ready", 32'(ready_o), 32'd1);
            check("l1_stream_valid", 32'(rvalid_o), 32'd1);
            check("l1_stream_rdata", rdata_o, e[i]);
            if (i < 4) begin
                req_we = 1'b0;
                req_addr = a[i + 1];
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("l1_stream_end", 32'(rvalid_o), 32'd0);

        // Reset while a store is waiting: no response, no commit.
        sel = 1'b0;
        old_val = $urandom;
        do_op(1'b1, 32'h30, old_val);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(rvalid_o), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_rel_valid", 32'(rvalid_o), 32'd0);
        do_op(1'b0, 32'h30, 32'h0);

        // Index wrap / range errors (model decides which applies).
        do_op(1'b1, 32'(DEPTH * 4), $urandom);
        do_op(1'b0, 32'h0, 32'h0);
        do_op(1'b0, 32'h3, 32'h0);

        // Valid pulsed during WAIT is ignored.
        d = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_wdata = d;
        @(posedge clk); @(negedge clk);
        req_addr = 32'h18; req_wdata = ~d;
        check("ign_wait_ready", 32'(ready_o), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("ign_resp_valid", 32'(rvalid_o), 32'd1);
        model[0][5] = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ign_no_extra", 32'(rvalid_o), 32'd0);
        end
        do_op(1'b0, 32'h14, 32'h0);
        do_op(1'b0, 32'h18, 32'h0);

        // Randomised ops against the model on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int k = 0; k < 24; k++) do_op(1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
